// File: rtl/ffsr_pulse_multi_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ffsr_pulse_multi_if : control/status bundle for ffsr_pulse_multi        |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface ffsr_pulse_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int CW     = $clog2(WIDTH + 1)
);
  logic [NUM_CH*WIDTH-1:0] init;
  logic [NUM_CH-1:0]       inc;
  logic [NUM_CH-1:0]       dec;
  logic                    leak_en;
  logic [NUM_CH*WIDTH-1:0] out;
  logic [NUM_CH*CW-1:0]    count;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       sat_err;

  modport master (
    output init, inc, dec, leak_en,
    input  out, count, full, empty, sat_err
  );

  modport slave (
    input  init, inc, dec, leak_en,
    output out, count, full, empty, sat_err
  );
endinterface
`default_nettype wire

// File: rtl/ffsr_pulse_multi.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ffsr_pulse_multi : NUM_CH thermometer registers with inc/dec/leak steps |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module ffsr_pulse_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int LEAK_PERIOD = 0
) (
  input  logic                clk,
  input  logic                rst,
  ffsr_pulse_multi_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [NUM_CH-1:0][WIDTH-1:0] out_q, out_d, w_init;
  logic [NUM_CH-1:0][CW-1:0]    count_q, count_d, w_init_cnt;
  logic [NUM_CH-1:0]            sat_q, sat_d, w_full, w_empty;
  logic                         w_leak_tick;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign w_init = bus.init;

  always_comb begin
    out_d      = out_q;
    count_d    = count_q;
    sat_d      = sat_q;
    w_full     = '0;
    w_empty    = '0;
    w_init_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]     = &out_q[c];
      w_empty[c]    = ~|out_q[c];
      w_init_cnt[c] = popcount(w_init[c]);
      if (bus.inc[c] && !bus.dec[c]) begin
        if (w_full[c]) begin
          sat_d[c] = 1'b1;
        end else begin
          out_d[c]   = {out_q[c][WIDTH-2:0], 1'b1};
          count_d[c] = count_q[c] + CW'(1);
        end
      end else if (!bus.inc[c] && (bus.dec[c] || w_leak_tick)) begin
        // A leak draining an empty channel is normal decay, not an error.
        if (w_empty[c]) begin
          sat_d[c] = sat_q[c] | bus.dec[c];
        end else begin
          out_d[c]   = {1'b0, out_q[c][WIDTH-1:1]};
          count_d[c] = count_q[c] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= w_init;
      count_q <= w_init_cnt;
      sat_q   <= '0;
    end else begin
      out_q   <= out_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  generate
    if (LEAK_PERIOD >= 2) begin : g_leak
      localparam int TW = $clog2(LEAK_PERIOD);
      logic [TW-1:0] timer_q, timer_d;

      assign w_leak_tick = bus.leak_en && (timer_q == TW'(LEAK_PERIOD - 1));

      always_comb begin
        timer_d = timer_q + TW'(1);
        if (!bus.leak_en || w_leak_tick) timer_d = '0;
      end

      always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
      end
    end else if (LEAK_PERIOD == 1) begin : g_leak_every
      assign w_leak_tick = bus.leak_en;
    end else begin : g_no_leak
      logic w_unused_leak_en;
      assign w_unused_leak_en = bus.leak_en;
      assign w_leak_tick      = 1'b0;
    end
  endgenerate

  assign bus.out     = out_q;
  assign bus.count   = count_q;
  assign bus.full    = w_full;
  assign bus.empty   = w_empty;
  assign bus.sat_err = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_ffsr_pulse_multi.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ffsr_pulse_multi : scoreboard bench for ffsr_pulse_multi             |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_ffsr_pulse_multi;

  localparam int NUM_CH      = 4;
  localparam int WIDTH       = 8;
  localparam int LEAK_PERIOD = 4;
  localparam int CW          = 4;

  typedef struct packed {
    logic [NUM_CH*WIDTH-1:0] out;
    logic [NUM_CH*CW-1:0]    cnt;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ffsr_pulse_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CW(CW)) bus ();

  ffsr_pulse_multi #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .LEAK_PERIOD(LEAK_PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb_q[$];
  logic [7:0] m_out [NUM_CH];
  int         m_cnt [NUM_CH];
  logic       m_sat [NUM_CH];
  int         m_timer = 0;

  // Advance the reference model by one edge, queue its prediction, clock the DUT, compare.
  task automatic cycle();
    exp_t e;
    bit   tick, up, dn, lk;
    tick = bus.leak_en && (m_timer == LEAK_PERIOD - 1);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_out[c] = bus.init[c*WIDTH +: WIDTH];
        m_cnt[c] = $countones(bus.init[c*WIDTH +: WIDTH]);
        m_sat[c] = 1'b0;
      end else begin
        up = bus.inc[c] && !bus.dec[c];
        dn = bus.dec[c] && !bus.inc[c];
        lk = !bus.inc[c] && !bus.dec[c] && tick;
        if (up) begin
          if (m_out[c] == 8'hFF) m_sat[c] = 1'b1;
          else begin m_out[c] = {m_out[c][6:0], 1'b1}; m_cnt[c]++; end
        end else if (dn || lk) begin
          if (m_out[c] == 8'h00) begin
            if (dn) m_sat[c] = 1'b1;
          end else begin
            m_out[c] = {1'b0, m_out[c][7:1]}; m_cnt[c]--;
          end
        end
      end
      e.out[c*WIDTH +: WIDTH] = m_out[c];
      e.cnt[c*CW +: CW]       = m_cnt[c][CW-1:0];
      e.full[c]               = (m_out[c] == 8'hFF);
      e.empty[c]              = (m_out[c] == 8'h00);
      e.sat[c]                = m_sat[c];
    end
    if (rst || !bus.leak_en || tick) m_timer = 0;
    else                             m_timer++;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: actual queue size 0, required 1");
    end else begin
      e = sb_q.pop_front();
      if (bus.out !== e.out) begin
        n_errors++;
        $display("FAIL sb_out: actual %h required %h", bus.out, e.out);
      end
      n_checks++;
      if (bus.count !== e.cnt) begin
        n_errors++;
        $display("FAIL sb_count: actual %h required %h", bus.count, e.cnt);
      end
      n_checks++;
      if (bus.full !== e.full) begin
        n_errors++;
        $display("FAIL sb_full: actual %b required %b", bus.full, e.full);
      end
      n_checks++;
      if (bus.empty !== e.empty) begin
        n_errors++;
        $display("FAIL sb_empty: actual %b required %b", bus.empty, e.empty);
      end
      n_checks++;
      if (bus.sat_err !== e.sat) begin
        n_errors++;
        $display("FAIL sb_sat_err: actual %b required %b", bus.sat_err, e.sat);
      end
    end
  endtask

  task automatic apply_reset(input logic [NUM_CH*WIDTH-1:0] v);
    bus.init = v;
    bus.inc  = '0;
    bus.dec  = '0;
    rst      = 1'b1;
    cycle();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    bus.leak_en = 1'b0;
    apply_reset({8'hFF, 8'h00, 8'h0F, 8'h07});
    n_checks++;
    if (bus.out[7:0] !== 8'h07 || bus.count[3:0] !== 4'd3) begin
      n_errors++;
      $display("FAIL reset_ch0: actual out=%h count=%0d required out=07 count=3",
               bus.out[7:0], bus.count[3:0]);
    end
    n_checks++;
    if (bus.full !== 4'b1000 || bus.empty !== 4'b0100 || bus.sat_err !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: actual full=%b empty=%b sat=%b required 1000 0100 0000",
               bus.full, bus.empty, bus.sat_err);
    end
  endtask

  task automatic test_inc_sat();
    bus.leak_en = 1'b0;
    apply_reset({8'hFF, 8'h00, 8'h0F, 8'h07});
    bus.inc = 4'b0001;
    for (int i = 0; i < 5; i++) cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'hFF || bus.count[3:0] !== 4'd8 || bus.full[0] !== 1'b1
        || bus.sat_err[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL inc_to_full: actual out=%h count=%0d full=%b sat=%b required FF 8 1 0",
               bus.out[7:0], bus.count[3:0], bus.full[0], bus.sat_err[0]);
    end
    cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'hFF || bus.sat_err[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL inc_saturate: actual out=%h sat=%b required FF 1",
               bus.out[7:0], bus.sat_err[0]);
    end
    bus.inc = '0;
    cycle();
    n_checks++;
    if (bus.sat_err[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_sticky: actual %b required 1", bus.sat_err[0]);
    end
  endtask

  task automatic test_cancel();
    bus.leak_en = 1'b0;
    apply_reset({8'h00, 8'hFF, 8'h01, 8'h0F});
    bus.inc = 4'b1111;
    bus.dec = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (bus.out !== 32'h00FF010F || bus.sat_err !== 4'b0000) begin
      n_errors++;
      $display("FAIL cancel_hold: actual out=%h sat=%b required 00FF010F 0000",
               bus.out, bus.sat_err);
    end
    apply_reset({8'h0F, 8'h0F, 8'h0F, 8'h00});
    bus.dec = 4'b0001;
    cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'h00 || bus.count[3:0] !== 4'd0 || bus.sat_err !== 4'b0001) begin
      n_errors++;
      $display("FAIL dec_underflow: actual out=%h count=%0d sat=%b required 00 0 0001",
               bus.out[7:0], bus.count[3:0], bus.sat_err);
    end
    bus.dec = '0;
  endtask

  task automatic test_leak();
    bus.leak_en = 1'b1;
    apply_reset({8'hFF, 8'h00, 8'h0F, 8'h0F});
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'h0F) begin
      n_errors++;
      $display("FAIL leak_early: actual %h required 0F", bus.out[7:0]);
    end
    bus.inc = 4'b0010;
    cycle();
    bus.inc = '0;
    n_checks++;
    if (bus.out !== 32'h7F001F07) begin
      n_errors++;
      $display("FAIL leak_tick1: actual %h required 7F001F07", bus.out);
    end
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'h03 || bus.out[23:16] !== 8'h00 || bus.sat_err !== 4'b0000) begin
      n_errors++;
      $display("FAIL leak_tick2: actual ch0=%h ch2=%h sat=%b required 03 00 0000",
               bus.out[7:0], bus.out[23:16], bus.sat_err);
    end
    bus.leak_en = 1'b0;
  endtask

  task automatic test_rst_mid();
    bus.leak_en = 1'b1;
    apply_reset({8'hFF, 8'h03, 8'h01, 8'h0F});
    bus.inc = 4'b1000;
    for (int i = 0; i < 2; i++) cycle();
    n_checks++;
    if (bus.sat_err !== 4'b1000) begin
      n_errors++;
      $display("FAIL mid_presat: actual %b required 1000", bus.sat_err);
    end
    bus.inc = 4'b1111;
    rst     = 1'b1;
    cycle();
    rst     = 1'b0;
    bus.inc = '0;
    n_checks++;
    if (bus.out !== 32'hFF03010F || bus.sat_err !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_reset: actual out=%h sat=%b required FF03010F 0000",
               bus.out, bus.sat_err);
    end
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'h0F) begin
      n_errors++;
      $display("FAIL mid_no_early_tick: actual %h required 0F", bus.out[7:0]);
    end
    cycle();
    n_checks++;
    if (bus.out[7:0] !== 8'h07) begin
      n_errors++;
      $display("FAIL mid_tick: actual %h required 07", bus.out[7:0]);
    end
    bus.leak_en = 1'b0;
  endtask

  task automatic test_random();
    logic [NUM_CH*WIDTH-1:0] v;
    logic [8:0]              t;
    for (int c = 0; c < NUM_CH; c++) begin
      t = (9'h001 << $urandom_range(0, WIDTH)) - 9'h001;
      v[c*WIDTH +: WIDTH] = t[7:0];
    end
    bus.leak_en = 1'b0;
    apply_reset(v);
    for (int i = 0; i < 300; i++) begin
      bus.inc     = 4'($urandom);
      bus.dec     = 4'($urandom);
      bus.leak_en = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.inc     = '0;
    bus.dec     = '0;
    bus.leak_en = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.init    = '0;
    bus.inc     = '0;
    bus.dec     = '0;
    bus.leak_en = 1'b0;
    test_reset();
    test_inc_sat();
    test_cancel();
    test_leak();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
